// File: rtl/counter_nbit_pkg.sv
// Shared constants and MODO operation codes for the N-bit counter.
// Modes are kept as a typed enum so every consumer decodes them identically.
package counter_nbit_pkg;

    localparam logic ALTO = 1'b1;
    localparam logic BAJO = 1'b0;

    typedef enum logic [1:0] {
        CUENTA_MAS_UNO   = 2'b00,
        CUENTA_MENOS_UNO = 2'b01,
        CUENTA_TRES_TRES = 2'b10,
        CARGA_D          = 2'b11
    } modo_e;

endpackage

// File: rtl/counter_nbit_next.sv
// Combinational next-count logic: wrap by default, clamp when COUNTER_NBIT_SATURATE_EN is defined.
// Reports the overflow/underflow event and whether the mode is a parallel load.
module counter_nbit_next
    import counter_nbit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 3
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [1:0]       modo_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_nxt_o,
    output logic             ovf_o,
    output logic             ld_o
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

    logic [WIDTH:0] sum;
    logic           down;

    always_comb begin
        sum  = '0;
        down = 1'b0;
        ld_o = 1'b0;
        case (modo_e'(modo_i))
            CUENTA_MAS_UNO:   sum = {1'b0, q_i} + ONE_X;
            // Q=0 borrows into the extra bit, so the same flag covers underflow.
            CUENTA_MENOS_UNO: begin
                sum  = {1'b0, q_i} - ONE_X;
                down = 1'b1;
            end
            CUENTA_TRES_TRES: sum = {1'b0, q_i} + STEP_X;
            CARGA_D: begin
                sum  = {1'b0, d_i};
                ld_o = 1'b1;
            end
        endcase
        ovf_o = sum[WIDTH];
`ifdef COUNTER_NBIT_SATURATE_EN
        if (ovf_o) q_nxt_o = down ? '0 : '1;
        else       q_nxt_o = sum[WIDTH-1:0];
`else
        q_nxt_o = sum[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/counter_nbit.sv
// N-bit up/down/step/load counter with async active-low reset and registered Q/RCO/LOAD.
// Define COUNTER_NBIT_SATURATE_EN to clamp at the limits instead of wrapping.
module counter_nbit
    import counter_nbit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             LOAD
);

    generate
        if (WIDTH < 2 || STEP < 1 || ((64'(STEP) >> WIDTH) != 64'd0)) begin : g_bad_param
            $error("counter_nbit: illegal WIDTH=%0d / STEP=%0d", WIDTH, STEP);
        end
    endgenerate

    logic [WIDTH-1:0] q_q, q_d, q_nxt;
    logic             rco_q, rco_d, load_q, load_d;
    logic             ovf, ld;

    counter_nbit_next #(.WIDTH(WIDTH), .STEP(STEP)) u_next (
        .q_i    (q_q),
        .modo_i (MODO),
        .d_i    (D),
        .q_nxt_o(q_nxt),
        .ovf_o  (ovf),
        .ld_o   (ld)
    );

`ifdef COUNTER_NBIT_SATURATE_EN
    // Set once a clamp has fired; repeated attempts at the limit stay silent.
    logic sat_q, sat_d;
`endif

    always_comb begin
        q_d    = q_q;
        rco_d  = BAJO;
        load_d = BAJO;
`ifdef COUNTER_NBIT_SATURATE_EN
        sat_d  = sat_q;
`endif
        if (ENABLE) begin
            q_d    = q_nxt;
            load_d = ld;
`ifdef COUNTER_NBIT_SATURATE_EN
            rco_d  = ovf & ~sat_q;
            sat_d  = ovf;
`else
            rco_d  = ovf;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q_q    <= '0;
            rco_q  <= BAJO;
            load_q <= BAJO;
`ifdef COUNTER_NBIT_SATURATE_EN
            sat_q  <= 1'b0;
`endif
        end else begin
            q_q    <= q_d;
            rco_q  <= rco_d;
            load_q <= load_d;
`ifdef COUNTER_NBIT_SATURATE_EN
            sat_q  <= sat_d;
`endif
        end
    end

    assign Q    = q_q;
    assign RCO  = rco_q;
    assign LOAD = load_q;

endmodule

// File: tb/tb_counter_nbit.sv
// Scoreboard bench: an 8-bit and a 2-bit counter (both STEP=3) driven in lockstep,
// checked against an integer-arithmetic reference model.
module tb_counter_nbit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ENABLE;
    logic [1:0] MODO;
    logic [7:0] D;
    logic [7:0] Q8;
    logic [1:0] Q2;
    logic       RCO8, LOAD8, RCO2, LOAD2;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    counter_nbit #(.WIDTH(8), .STEP(3)) dut8 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODO(MODO), .D(D),
        .Q(Q8), .RCO(RCO8), .LOAD(LOAD8)
    );

    counter_nbit #(.WIDTH(2), .STEP(3)) dut2 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODO(MODO), .D(D[1:0]),
        .Q(Q2), .RCO(RCO2), .LOAD(LOAD2)
    );

    typedef struct {
        int q8; bit rco8; bit ld8;
        int q2; bit rco2; bit ld2;
    } exp_t;

    exp_t sb[$];

    int m8 = 0, m2 = 0;
    bit s8 = 0, s2 = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, out-of-range results folded or clamped.
    function automatic void mstep(input int w, input int q, input bit sat_in,
                                  input bit en, input int md, input int d,
                                  output int qn, output bit rco, output bit ld,
                                  output bit sat_out);
        int m;
        int t;
        m = 1 << w;
        qn = q; rco = 0; ld = 0; sat_out = sat_in;
        if (!en) return;
        if (md == 3) begin
            qn = d % m; ld = 1; sat_out = 0;
            return;
        end
        t = (md == 0) ? q + 1 : (md == 1) ? q - 1 : q + 3;
        if (t >= 0 && t < m) begin
            qn = t; sat_out = 0;
        end else begin
`ifdef COUNTER_NBIT_SATURATE_EN
            qn = (t < 0) ? 0 : m - 1;
            rco = !sat_in;
            sat_out = 1;
`else
            qn = (t + m) % m;
            rco = 1;
`endif
        end
    endfunction

    task automatic drive(input bit rst, input bit en, input logic [1:0] md, input logic [7:0] dv);
        exp_t e;
        bit   ns;
        @(negedge CLK);
        RESET = rst; ENABLE = en; MODO = md; D = dv;
        if (!rst) begin
            m8 = 0; m2 = 0; s8 = 0; s2 = 0;
            e = '{0, 0, 0, 0, 0, 0};
        end else begin
            mstep(8, m8, s8, en, int'(md), int'(dv), e.q8, e.rco8, e.ld8, ns); s8 = ns;
            mstep(2, m2, s2, en, int'(md), int'(dv), e.q2, e.rco2, e.ld2, ns); s2 = ns;
            m8 = e.q8; m2 = e.q2;
        end
        sb.push_back(e);
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("Q8",    int'(Q8),    e.q8);
            chk("RCO8",  int'(RCO8),  int'(e.rco8));
            chk("LOAD8", int'(LOAD8), int'(e.ld8));
            chk("Q2",    int'(Q2),    e.q2);
            chk("RCO2",  int'(RCO2),  int'(e.rco2));
            chk("LOAD2", int'(LOAD2), int'(e.ld2));
        end
    end

    initial begin
        int guard;
        RESET = 1'b0; ENABLE = 1'b0; MODO = 2'b00; D = 8'h00;
        #2;
        chk("rst_Q8", int'(Q8), 0);
        chk("rst_RCO8", int'(RCO8), 0);
        chk("rst_LOAD8", int'(LOAD8), 0);
        drive(0, 1, 2'b00, 8'h00);
        drive(0, 1, 2'b00, 8'h00);

        // Count to 5, then reset asynchronously between edges.
        drive(1, 1, 2'b11, 8'h00);
        repeat (5) drive(1, 1, 2'b00, 8'h00);
        @(posedge CLK); #3;
        RESET = 1'b0;
        #1;
        chk("async_rst_Q8", int'(Q8), 0);
        chk("async_rst_RCO8", int'(RCO8), 0);
        chk("async_rst_LOAD8", int'(LOAD8), 0);
        chk("async_rst_Q2", int'(Q2), 0);
        drive(0, 1, 2'b00, 8'h00);
        drive(1, 1, 2'b00, 8'h00);

        // Up wrap from 253.
        drive(1, 1, 2'b11, 8'd253);
        repeat (4) drive(1, 1, 2'b00, 8'h00);
        // Down wrap from 1, then hold.
        drive(1, 1, 2'b11, 8'd1);
        repeat (2) drive(1, 1, 2'b01, 8'h00);
        repeat (3) drive(1, 0, 2'b01, 8'h00);
        // Step mode from 250; the 2-bit instance wraps on consecutive edges.
        drive(1, 1, 2'b11, 8'd250);
        repeat (4) drive(1, 1, 2'b10, 8'h00);
        // Load twice, then count.
        repeat (2) drive(1, 1, 2'b11, 8'hA5);
        drive(1, 1, 2'b00, 8'h00);
        // Limits with load of extreme values.
        drive(1, 1, 2'b11, 8'd254);
        repeat (3) drive(1, 1, 2'b00, 8'h00);
        drive(1, 1, 2'b11, 8'hFF);
        drive(1, 1, 2'b11, 8'd1);
        repeat (3) drive(1, 1, 2'b01, 8'h00);
        drive(1, 1, 2'b11, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge CLK);
            guard++;
        end
        #2;
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
